// File: rtl/morse_tx.sv
// Morse code transmitter: keys out one letter A..Z as marks and spaces,
// followed by an inter-letter gap, with optional retransmission.
module morse_tx #(
  parameter int unsigned UNIT_TICKS = 250,
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned GAP_UNITS  = 3
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [4:0] Letter,
  input  logic       Repeat,
  output logic       DotDashOut,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam int unsigned     DW        = $clog2(UNIT_TICKS);
  localparam logic [DW-1:0]   DIV_LOAD  = DW'(UNIT_TICKS - 1);
  localparam logic [2:0]      DASH_LOAD = 3'(DASH_UNITS - 1);
  localparam logic [2:0]      GAP_LOAD  = 3'(GAP_UNITS - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    units;
  logic [3:0]    pat;
  logic [2:0]    cnt;
  logic [1:0]    idx;

  logic [3:0]    tbl_pat;
  logic [2:0]    tbl_cnt;
  logic          letter_ok;
  logic [2:0]    idx_next;
  logic          more_syms;
  logic          next_is_dash;
  logic          first_is_dash;
  logic          state_end;

  // Code table: patterns are left-aligned, first symbol in bit 3, dash=1.
  always_comb begin
    tbl_pat = '0;
    tbl_cnt = '0;
    case (Letter)
      5'd0:  begin tbl_pat = 4'b0100; tbl_cnt = 3'd2; end // A .-
      5'd1:  begin tbl_pat = 4'b1000; tbl_cnt = 3'd4; end // B -...
      5'd2:  begin tbl_pat = 4'b1010; tbl_cnt = 3'd4; end // C -.-.
      5'd3:  begin tbl_pat = 4'b1000; tbl_cnt = 3'd3; end // D -..
      5'd4:  begin tbl_pat = 4'b0000; tbl_cnt = 3'd1; end // E .
      5'd5:  begin tbl_pat = 4'b0010; tbl_cnt = 3'd4; end // F ..-.
      5'd6:  begin tbl_pat = 4'b1100; tbl_cnt = 3'd3; end // G --.
      5'd7:  begin tbl_pat = 4'b0000; tbl_cnt = 3'd4; end // H ....
      5'd8:  begin tbl_pat = 4'b0000; tbl_cnt = 3'd2; end // I ..
      5'd9:  begin tbl_pat = 4'b0111; tbl_cnt = 3'd4; end // J .---
      5'd10: begin tbl_pat = 4'b1010; tbl_cnt = 3'd3; end // K -.-
      5'd11: begin tbl_pat = 4'b0100; tbl_cnt = 3'd4; end // L .-..
      5'd12: begin tbl_pat = 4'b1100; tbl_cnt = 3'd2; end // M --
      5'd13: begin tbl_pat = 4'b1000; tbl_cnt = 3'd2; end // N -.
      5'd14: begin tbl_pat = 4'b1110; tbl_cnt = 3'd3; end // O ---
      5'd15: begin tbl_pat = 4'b0110; tbl_cnt = 3'd4; end // P .--.
      5'd16: begin tbl_pat = 4'b1101; tbl_cnt = 3'd4; end // Q --.-
      5'd17: begin tbl_pat = 4'b0100; tbl_cnt = 3'd3; end // R .-.
      5'd18: begin tbl_pat = 4'b0000; tbl_cnt = 3'd3; end // S ...
      5'd19: begin tbl_pat = 4'b1000; tbl_cnt = 3'd1; end // T -
      5'd20: begin tbl_pat = 4'b0010; tbl_cnt = 3'd3; end // U ..-
      5'd21: begin tbl_pat = 4'b0001; tbl_cnt = 3'd4; end // V ...-
      5'd22: begin tbl_pat = 4'b0110; tbl_cnt = 3'd3; end // W .--
      5'd23: begin tbl_pat = 4'b1001; tbl_cnt = 3'd4; end // X -..-
      5'd24: begin tbl_pat = 4'b1011; tbl_cnt = 3'd4; end // Y -.--
      5'd25: begin tbl_pat = 4'b1100; tbl_cnt = 3'd4; end // Z --..
      default: begin tbl_pat = '0; tbl_cnt = '0; end
    endcase
  end

  assign letter_ok     = (Letter <= 5'd25);
  assign idx_next      = {1'b0, idx} + 3'd1;
  assign more_syms     = (idx_next < cnt);
  assign next_is_dash  = pat[2'd3 - idx_next[1:0]];
  assign first_is_dash = pat[3];
  // A state's time is up when both the tick divider and the unit count are spent.
  assign state_end     = (div == '0) && (units == '0);

  // Symbol sequencer: divider/unit counting plus registered key and status outputs.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      div        <= '0;
      units      <= '0;
      pat        <= '0;
      cnt        <= '0;
      idx        <= '0;
      DotDashOut <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          if (letter_ok) begin
            pat        <= tbl_pat;
            cnt        <= tbl_cnt;
            idx        <= '0;
            div        <= DIV_LOAD;
            units      <= tbl_pat[3] ? DASH_LOAD : 3'd0;
            state      <= MARK;
            DotDashOut <= 1'b1;
            Busy       <= 1'b1;
          end else begin
            Error <= 1'b1;
          end
        end
      end else if (!state_end) begin
        // Common timing for MARK/SPACE/GAP: count ticks down, then whole units.
        if (div != '0) begin
          div <= div - 1'b1;
        end else begin
          div   <= DIV_LOAD;
          units <= units - 3'd1;
        end
      end else begin
        div <= DIV_LOAD;
        case (state)
          MARK: begin
            DotDashOut <= 1'b0;
            if (more_syms) begin
              state <= SPACE;
              units <= 3'd0;
            end else begin
              state <= GAP;
              units <= GAP_LOAD;
            end
          end
          SPACE: begin
            idx        <= idx_next[1:0];
            units      <= next_is_dash ? DASH_LOAD : 3'd0;
            state      <= MARK;
            DotDashOut <= 1'b1;
          end
          GAP: begin
            Done <= 1'b1;
            if (Repeat) begin
              idx        <= '0;
              units      <= first_is_dash ? DASH_LOAD : 3'd0;
              state      <= MARK;
              DotDashOut <= 1'b1;
            end else begin
              units <= '0;
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_TICKS=4, DASH_UNITS=3, GAP_UNITS=3.
module tb_morse_tx;

  logic       ClockIn;
  logic       Resetn;
  logic       Start;
  logic [4:0] Letter;
  logic       Repeat;
  logic       DotDashOut;
  logic       Busy;
  logic       Done;
  logic       Error;

  int n_checks = 0;
  int n_fail   = 0;

  morse_tx #(
    .UNIT_TICKS (4),
    .DASH_UNITS (3),
    .GAP_UNITS  (3)
  ) dut (
    .ClockIn    (ClockIn),
    .Resetn     (Resetn),
    .Start      (Start),
    .Letter     (Letter),
    .Repeat     (Repeat),
    .DotDashOut (DotDashOut),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at the negedge holding the first cycle of a run; returns at the
  // negedge holding the first cycle after it. Bounded by exp+8 cycles.
  task automatic measure_run(input string tag, input logic lvl, input int exp);
    int n = 0;
    while (DotDashOut === lvl && Busy === 1'b1 && n < exp + 8) begin
      n++;
      @(negedge ClockIn);
    end
    check(tag, n, exp);
  endtask

  // Present Start for one edge; returns at the first negedge after acceptance.
  task automatic send(input logic [4:0] l);
    Start  = 1'b1;
    Letter = l;
    @(negedge ClockIn);
    Start  = 1'b0;
  endtask

  task automatic expect_idle_done(input string tag);
    check({tag, "_done"}, Done, 1);
    check({tag, "_busy_off"}, Busy, 0);
    @(negedge ClockIn);
    check({tag, "_done_once"}, Done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0;
    Start  = 1'b0;
    Letter = '0;
    Repeat = 1'b0;
    repeat (3) @(negedge ClockIn);
    check("rst_dd", DotDashOut, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", Error, 0);

    // E accepted on the first edge after reset release
    Resetn = 1'b1;
    send(5'd4);
    measure_run("E_mark", 1'b1, 4);
    measure_run("E_gap", 1'b0, 12);
    expect_idle_done("E");

    // A: dot, space, dash, gap
    send(5'd0);
    measure_run("A_dot", 1'b1, 4);
    measure_run("A_space", 1'b0, 4);
    measure_run("A_dash", 1'b1, 12);
    measure_run("A_gap", 1'b0, 12);
    expect_idle_done("A");

    // invalid letter
    send(5'd27);
    check("inv_err", Error, 1);
    check("inv_busy", Busy, 0);
    check("inv_dd", DotDashOut, 0);
    check("inv_done", Done, 0);
    @(negedge ClockIn);
    check("inv_err_once", Error, 0);
    check("inv_still_idle", Busy, 0);

    // T with a Start/Letter change while busy
    send(5'd19);
    Start  = 1'b1;
    Letter = 5'd4;
    measure_run("T_dash", 1'b1, 12);
    Start  = 1'b0;
    measure_run("T_gap", 1'b0, 12);
    expect_idle_done("T");
    check("T_no_restart", Busy, 0);

    // E repeated three times, Repeat dropped during the third mark
    Repeat = 1'b1;
    send(5'd4);
    measure_run("R1_mark", 1'b1, 4);
    measure_run("R1_gap", 1'b0, 12);
    check("R1_done", Done, 1);
    check("R1_busy_held", Busy, 1);
    measure_run("R2_mark", 1'b1, 4);
    measure_run("R2_gap", 1'b0, 12);
    check("R2_done", Done, 1);
    check("R2_busy_held", Busy, 1);
    Repeat = 1'b0;
    measure_run("R3_mark", 1'b1, 4);
    measure_run("R3_gap", 1'b0, 12);
    expect_idle_done("R3");

    // reset during first dash of B
    send(5'd1);
    repeat (4) @(negedge ClockIn);
    check("B_in_dash", DotDashOut, 1);
    #1;
    Resetn = 1'b0;
    #1;
    check("B_rst_dd_async", DotDashOut, 0);
    check("B_rst_busy_async", Busy, 0);
    repeat (2) @(negedge ClockIn);
    check("B_rst_no_done", Done, 0);
    Resetn = 1'b1;
    send(5'd4);
    measure_run("E2_mark", 1'b1, 4);
    measure_run("E2_gap", 1'b0, 12);
    expect_idle_done("E2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter UNIT_TICKS, default 250: ClockIn cycles per Morse time unit; legal range 2..65535.
REQ-002 Parameter DASH_UNITS, default 3: length of a dash in units; legal range 2..7.
REQ-003 Parameter GAP_UNITS, default 3: inter-letter gap after the last symbol, in units; legal range 1..7.
REQ-004 ClockIn  input  1  single clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  asynchronous, active-low reset; asserting it forces reset state immediately, and release is synchronous to ClockIn.
REQ-006 Start  input  1  level request; the cycle it is accepted starts transmission of Letter.
REQ-007 Letter  input  5  letter code, 0=A .. 25=Z; values 26..31 are invalid.
REQ-008 Repeat  input  1  when high at the end of a letter's gap, the latched letter is retransmitted.
REQ-009 DotDashOut  output  1  Morse key output, high during a mark.
REQ-010 Busy  output  1  high from the cycle after acceptance until the gap completes.
REQ-011 Done  output  1  one-cycle pulse marking completion of a letter, including its gap.
REQ-012 Error  output  1  one-cycle pulse when Start is seen in IDLE with an invalid Letter.

Function
REQ-013 The code table SHALL be fixed, MSB symbol first, with dot=0 and dash=1, stored as a 4-bit pattern plus a 3-bit count (1..4): A .- B -... C -.-. D -.. E . F ..-. G --. H .... I .. J .--- K -.- L .-.. M -- N -. O --- P .--. Q --.- R .-. S ... T - U ..- V ...- W .-- X -..- Y -.-- Z --..
REQ-014 FSM states SHALL be IDLE, MARK, SPACE and GAP; all outputs are registered.
REQ-015 The rate divider SHALL have width clog2(UNIT_TICKS), load UNIT_TICKS-1 on entry to each state, and count down; one unit elapses when it reaches 0.
REQ-016 IDLE: when Start=1 and Letter<=25 on an edge, the block SHALL latch the pattern and count, clear the symbol index, enter MARK, and set DotDashOut=1 and Busy=1 from the next cycle.
REQ-017 IDLE: when Start=1 and Letter>25, the block SHALL pulse Error for one cycle and remain in IDLE.
REQ-018 MARK SHALL hold DotDashOut=1 for exactly UNIT_TICKS cycles for a dot and DASH_UNITS*UNIT_TICKS cycles for a dash.
REQ-019 When a MARK ends, the block SHALL go to SPACE if more symbols remain, otherwise to GAP; DotDashOut=0 in both.
REQ-020 SPACE SHALL last exactly UNIT_TICKS cycles, then advance the symbol index and return to MARK.
REQ-021 GAP SHALL last exactly GAP_UNITS*UNIT_TICKS cycles; at its final cycle, Done SHALL pulse on the next cycle.
REQ-022 If Repeat=0 at the end of GAP, the next state SHALL be IDLE with Busy=0; Start in that same Done cycle SHALL be accepted.
REQ-023 If Repeat=1 at the end of GAP, the next state SHALL be MARK with the latched letter, Busy held at 1, and Done still pulsed.
REQ-024 Start and Letter SHALL be ignored outside IDLE; a change of Letter mid-transmission has no effect.
REQ-025 Total busy time SHALL be the sum of marks + (count-1)*UNIT_TICKS + GAP_UNITS*UNIT_TICKS cycles.

Reset
REQ-026 While Resetn=0: state=IDLE, DotDashOut=0, Busy=0, Done=0, Error=0, divider=0, symbol index=0, latched pattern=0.
REQ-027 Reset asserted mid-transmission SHALL drop DotDashOut and Busy without waiting for a clock edge; no Done is produced.
REQ-028 After reset release, the block SHALL accept Start on the first rising edge.

Verification (UNIT_TICKS=4, DASH_UNITS=3, GAP_UNITS=3)
REQ-029 Letter=4 (E), Start for one cycle -> DotDashOut high 4 cycles then low 12; Busy high for 16 cycles; Done pulses once at the IDLE entry.
REQ-030 Letter=0 (A) -> DotDashOut pattern: 4 high, 4 low, 12 high, 12 low; Busy for 32 cycles.
REQ-031 Letter=27 with Start -> one-cycle Error pulse; Busy, DotDashOut and Done stay 0.
REQ-032 Start Letter=19 (T), then pulse Start with Letter=4 while Busy -> only T is sent (12 high, 12 low).
REQ-033 Letter=4 with Repeat=1 held -> DotDashOut repeats a 4-high/12-low period; Busy stays 1 continuously; Done pulses every 16 cycles; dropping Repeat stops after the current letter.
REQ-034 Resetn pulsed low during the first dash of B -> DotDashOut=0 and Busy=0 asynchronously; after release, Start with Letter=4 produces a clean E.
